// File: rtl/edge_detector_mc.sv
// edge_detector_mc: multi-channel edge detector for noisy or asynchronous
// single-bit inputs. Each channel has its own synchroniser, an optional
// debounce filter, an edge detector with a runtime mode mask, and a sticky
// flag. The sticky flags are ORed together to form one interrupt line.
module edge_detector_mc #(
  parameter int CH              = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   signal_i,
  input  logic [2*CH-1:0] mode_i,
  input  logic [CH-1:0]   clear_i,
  output logic [CH-1:0]   level_o,
  output logic [CH-1:0]   detect_o,
  output logic [CH-1:0]   sticky_o,
  output logic            irq_o
);

  // Counter width is derived from the debounce depth, with a minimum of
  // one bit; no counter is built when debounce is bypassed.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   sync_s;
      logic                   level;
      logic                   level_dly_q;
      logic                   rise;
      logic                   fall;
      logic                   detect;
      logic                   sticky_q;

      // Synchroniser shift chain; bit 0 captures the raw input.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= signal_i[gi];
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign sync_s = sync_q[SYNC_STAGES-1];

      if (DEBOUNCE_CYCLES > 0) begin : g_deb
        // Index of the last mismatch before the filtered level is allowed
        // to follow the synchronised input.
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;

        // Count consecutive mismatching samples; commit on the D-th one.
        // A matching sample restarts the count, which rejects short glitches
        // and keeps the counter strictly below D.
        always_comb begin
          cnt_d   = '0;
          level_d = level_q;
          if (sync_s != level_q) begin
            if (cnt_q == CNT_LAST) begin
              level_d = sync_s;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end

        // Debounce state registers.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
          end
        end

        assign level = level_q;
      end else begin : g_nodeb
        // Debounce bypassed: the filtered level is the synchroniser output.
        assign level = sync_s;
      end

      // Previous-cycle copy of the filtered level for edge detection.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          level_dly_q <= 1'b0;
        end else begin
          level_dly_q <= level;
        end
      end

      // Edges are derived from registers only; the mode mask applies at once.
      assign rise   = level & ~level_dly_q;
      assign fall   = ~level & level_dly_q;
      assign detect = (rise & mode_i[2*gi]) | (fall & mode_i[2*gi+1]);

      // Sticky flag: a new event has priority over a simultaneous clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sticky_q <= 1'b0;
        end else if (detect) begin
          sticky_q <= 1'b1;
        end else if (clear_i[gi]) begin
          sticky_q <= 1'b0;
        end
      end

      assign level_o[gi]  = level;
      assign detect_o[gi] = detect;
      assign sticky_o[gi] = sticky_q;
    end
  endgenerate

  assign irq_o = |sticky_o;

endmodule

// File: tb/tb_edge_detector_mc.sv
// Testbench for edge_detector_mc: two builds (S=2/D=4 and S=1/D=0) share
// stimulus and are checked every cycle against a history-based model, plus
// a few hand-computed literal expectations.
module tb_edge_detector_mc;
  localparam int CH = 4;
  localparam int SA = 2, DA = 4;
  localparam int SB = 1, DB = 0;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   signal_i;
  logic [2*CH-1:0] mode_i;
  logic [CH-1:0]   clear_i;

  logic [CH-1:0] lvl_a, det_a, stk_a;
  logic          irq_a;
  logic [CH-1:0] lvl_b, det_b, stk_b;
  logic          irq_b;

  int tests  = 0;
  int failed = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  edge_detector_mc #(.CH(CH), .SYNC_STAGES(SA), .DEBOUNCE_CYCLES(DA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .signal_i(signal_i), .mode_i(mode_i),
    .clear_i(clear_i), .level_o(lvl_a), .detect_o(det_a),
    .sticky_o(stk_a), .irq_o(irq_a)
  );

  edge_detector_mc #(.CH(CH), .SYNC_STAGES(SB), .DEBOUNCE_CYCLES(DB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .signal_i(signal_i), .mode_i(mode_i),
    .clear_i(clear_i), .level_o(lvl_b), .detect_o(det_b),
    .sticky_o(stk_b), .irq_o(irq_b)
  );

  // ---------------- behavioural model ----------------
  // hist[k] is signal_i as sampled on the k-th rising edge since reset.
  logic [CH-1:0] hist[$];
  logic [CH-1:0] ma_level, ma_prev, ma_sticky;
  logic [CH-1:0] mb_level, mb_prev, mb_sticky;

  function automatic logic [CH-1:0] hget(int j);
    if (j < 0 || j >= hist.size()) return '0;
    return hist[j];
  endfunction

  // Level after edge k: the synchronised value after edge j is the raw
  // sample from edge j-S+1. With D>0 the level flips only when the D
  // synchronised values seen by edges k-D+1..k all differ from it.
  function automatic logic [CH-1:0] next_level(int s, int d, logic [CH-1:0] old, int k);
    logic [CH-1:0] res;
    if (d == 0) return hget(k - s + 1);
    res = old;
    for (int c = 0; c < CH; c++) begin
      bit all_diff = 1'b1;
      for (int j = k - d; j <= k - 1; j++) begin
        logic [CH-1:0] v;
        v = hget(j - s + 1);
        if (v[c] == old[c]) all_diff = 1'b0;
      end
      if (all_diff) res[c] = ~old[c];
    end
    return res;
  endfunction

  function automatic logic [CH-1:0] exp_det(logic [CH-1:0] l, logic [CH-1:0] p,
                                            logic [2*CH-1:0] m);
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++)
      r[c] = (l[c] & ~p[c] & m[2*c]) | (~l[c] & p[c] & m[2*c+1]);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      ma_level = '0; ma_prev = '0; ma_sticky = '0;
      mb_level = '0; mb_prev = '0; mb_sticky = '0;
    end else begin
      int k;
      ma_sticky = exp_det(ma_level, ma_prev, mode_i) | (ma_sticky & ~clear_i);
      mb_sticky = exp_det(mb_level, mb_prev, mode_i) | (mb_sticky & ~clear_i);
      hist.push_back(signal_i);
      k = hist.size() - 1;
      ma_prev  = ma_level;
      ma_level = next_level(SA, DA, ma_level, k);
      mb_prev  = mb_level;
      mb_level = next_level(SB, DB, mb_level, k);
    end
  end

  // ---------------- checking ----------------
  task automatic check(string name, logic [CH-1:0] act, logic [CH-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_level",  lvl_a, ma_level);
      check("a_detect", det_a, exp_det(ma_level, ma_prev, mode_i));
      check("a_sticky", stk_a, ma_sticky);
      check("a_irq",    {3'b0, irq_a}, {3'b0, |ma_sticky});
      check("b_level",  lvl_b, mb_level);
      check("b_detect", det_b, exp_det(mb_level, mb_prev, mode_i));
      check("b_sticky", stk_b, mb_sticky);
      check("b_irq",    {3'b0, irq_b}, {3'b0, |mb_sticky});
    end
  end

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  int hold[CH];

  initial begin
    rst_n    = 1'b0;
    signal_i = '0;
    mode_i   = 8'h55;
    clear_i  = '0;
    chk_en   = 1'b1;
    tick(2);
    check("rst_level", lvl_a, 4'h0);
    check("rst_sticky", stk_a, 4'h0);
    rst_n = 1'b1;

    // Basic rise on ch0: A pulses after edge 6, B after edge 1.
    signal_i = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 1) check("b_pulse_e1", det_b, 4'b0001);
      if (e == 2) check("b_pulse_e2", det_b, 4'b0000);
      if (e == 5) check("a_nopulse_e5", det_a, 4'b0000);
      if (e == 6) begin
        check("a_pulse_e6", det_a, 4'b0001);
        check("a_level_e6", lvl_a, 4'b0001);
      end
      if (e == 7) begin
        check("a_sticky_e7", stk_a, 4'b0001);
        check("a_irq_e7", {3'b0, irq_a}, 4'b0001);
        check("a_detect_e7", det_a, 4'b0000);
      end
    end
    clear_i = '1; tick(); clear_i = '0;

    // Glitch of 3 cycles on ch1 is rejected.
    signal_i[1] = 1'b1; tick(3); signal_i[1] = 1'b0; tick(10);
    check("glitch3_level", lvl_a, 4'b0001);
    check("glitch3_sticky", stk_a, 4'b0000);
    // 4 cycles passes: rise only under mode 01.
    signal_i[1] = 1'b1; tick(4); signal_i[1] = 1'b0; tick(12);
    check("glitch4_sticky", stk_a, 4'b0010);

    // Mode sweep on ch2: both, fall-only, none.
    mode_i[5:4] = 2'b11; signal_i[2] = 1'b1; tick(10); signal_i[2] = 1'b0; tick(10);
    mode_i[5:4] = 2'b10; signal_i[2] = 1'b1; tick(10); signal_i[2] = 1'b0; tick(10);
    mode_i[5:4] = 2'b00; signal_i[2] = 1'b1; tick(10);
    check("mode00_level", lvl_a & 4'b0100, 4'b0100);
    signal_i[2] = 1'b0; tick(10);
    mode_i = 8'h55;

    // Sticky set wins over simultaneous clear on ch3.
    clear_i = '1; tick(2); clear_i = '0;
    signal_i[3] = 1'b1; tick(6);
    check("sticky_det", det_a, 4'b1000);
    clear_i[3] = 1'b1; tick();
    check("sticky_setwins", stk_a, 4'b1000);
    tick();
    check("sticky_cleared", stk_a, 4'b0000);
    check("irq_cleared", {3'b0, irq_a}, 4'b0000);
    clear_i = '0;

    // Reset asserted mid-debounce clears everything at once.
    signal_i = '0; tick(12);
    signal_i = 4'hF; tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("async_level", lvl_a | lvl_b, 4'h0);
    check("async_sticky", stk_a | stk_b, 4'h0);
    check("async_detect", det_a | det_b, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // Input already high at release counts as a rising edge.
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 1) check("rel_b_pulse", det_b, 4'hF);
      if (e == 5) check("rel_a_nopulse", det_a, 4'h0);
      if (e == 6) check("rel_a_pulse", det_a, 4'hF);
    end

    // Randomised phase: bursty inputs, occasional mode changes and clears.
    for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 8);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          signal_i[c] = ~signal_i[c];
          hold[c] = $urandom_range(1, 8);
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 49) == 0) mode_i = 8'($urandom());
      clear_i = ($urandom_range(0, 9) == 0) ? 4'($urandom()) : 4'h0;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
